// File: rtl/restore_multiplier_if.sv
// Operand/result bundle for restore_multiplier.
// master drives operands, slave returns the dividend.
interface restore_multiplier_if #(
    parameter int WIDTH = 4
);
    logic [2*WIDTH-1:0] quotient;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   remainder;
    logic               din_valid;
    logic [3*WIDTH-1:0] dout;
    logic               dout_valid;
    logic               busy;

    modport master (
        output quotient, divisor, remainder, din_valid,
        input  dout, dout_valid, busy
    );

    modport slave (
        input  quotient, divisor, remainder, din_valid,
        output dout, dout_valid, busy
    );
endinterface

// File: rtl/restore_multiplier.sv
// Rebuilds a dividend as quotient*divisor+remainder
// with an LSB-first shift-add loop of 2*WIDTH steps.
module restore_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    restore_multiplier_if.slave  bus
);
    localparam int QW = 2 * WIDTH;
    localparam int RW = 3 * WIDTH;
    localparam int CW = (QW > 1) ? $clog2(QW) : 1;

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] acc_q, acc_d;
    logic [RW-1:0] add_q, add_d;
    logic [QW-1:0] q_q, q_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] dout_q, dout_d;
    logic          dv_q, dv_d;
    logic [RW-1:0] sum;

    // State register; reset wins over capture and any step.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            add_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            add_q   <= add_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
        end
    end

    // Capture in IDLE, one shift-add step per CALC cycle.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        add_d   = add_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        dv_d    = 1'b0;
        sum     = acc_q;
        unique case (state_q)
            IDLE: begin
                if (bus.din_valid) begin
                    acc_d   = {{QW{1'b0}}, bus.remainder};
                    add_d   = {{QW{1'b0}}, bus.divisor};
                    q_d     = bus.quotient;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                sum   = q_q[0] ? (acc_q + add_q) : acc_q;
                acc_d = sum;
                add_d = add_q << 1;
                q_d   = q_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(QW - 1)) begin
                    dout_d  = sum;
                    dv_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dv_q;
    assign bus.busy       = (state_q == CALC);
endmodule

// File: tb/tb_restore_multiplier.sv
// Directed and random checks of restore_multiplier
// with WIDTH=4 against hand-computed q*d+r values.
module tb_restore_multiplier;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    restore_multiplier_if #(.WIDTH(4)) mif ();

    restore_multiplier #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (mif.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [7:0] q,
                         input logic [3:0] d,
                         input logic [3:0] r);
        mif.quotient  = q;
        mif.divisor   = d;
        mif.remainder = r;
        mif.din_valid = 1'b1;
        tick();
        mif.din_valid = 1'b0;
    endtask

    task automatic wait_dv(input string tag,
                           input logic [11:0] exp,
                           input int lat);
        int  n    = 0;
        bit  seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            n++;
            if (mif.dout_valid) seen = 1'b1;
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk(tag, 32'(mif.dout), 32'(exp));
            chk({tag, "_lat"}, n, lat);
        end
    endtask

    task automatic run(input string tag,
                       input logic [7:0] q,
                       input logic [3:0] d,
                       input logic [3:0] r,
                       input logic [11:0] exp);
        start(q, d, r);
        chk({tag, "_busy"}, 32'(mif.busy), 32'd1);
        wait_dv(tag, exp, 8);
    endtask

    initial begin
        int pulses;
        int q, d, r;

        mif.quotient  = '0;
        mif.divisor   = '0;
        mif.remainder = '0;
        mif.din_valid = 1'b0;
        tick();
        tick();
        chk("rst_dout", 32'(mif.dout), 32'd0);
        chk("rst_dv", 32'(mif.dout_valid), 32'd0);
        chk("rst_busy", 32'(mif.busy), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_busy", 32'(mif.busy), 32'd0);

        // basic: 13*3+2 = 41, busy through all 8 steps
        start(8'h0D, 4'h3, 4'h2);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1_busy%0d", i), 32'(mif.busy), 32'd1);
            chk($sformatf("t1_dv%0d", i), 32'(mif.dout_valid), 32'd0);
            tick();
        end
        chk("t1_dv", 32'(mif.dout_valid), 32'd1);
        chk("t1_dout", 32'(mif.dout), 32'h029);
        chk("t1_idle", 32'(mif.busy), 32'd0);
        tick();
        chk("t1_dv_off", 32'(mif.dout_valid), 32'd0);
        chk("t1_hold", 32'(mif.dout), 32'h029);

        run("max", 8'hFF, 4'hF, 4'hE, 12'hEFF);
        run("d0", 8'hA5, 4'h0, 4'h7, 12'h007);
        run("q0", 8'h00, 4'h9, 4'h5, 12'h005);

        // request while busy is dropped, request on pulse is taken
        start(8'h0D, 4'h3, 4'h2);
        tick();
        tick();
        mif.quotient  = 8'hFF;
        mif.divisor   = 4'hF;
        mif.remainder = 4'hE;
        mif.din_valid = 1'b1;
        tick();
        mif.din_valid = 1'b0;
        wait_dv("ign", 12'h029, 5);
        start(8'hFF, 4'hF, 4'hE);
        chk("b2b_busy", 32'(mif.busy), 32'd1);
        wait_dv("b2b", 12'hEFF, 8);

        // reset in CALC aborts without a pulse
        start(8'h0D, 4'h3, 4'h2);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(mif.busy), 32'd0);
        chk("abort_dout", 32'(mif.dout), 32'd0);
        chk("abort_dv", 32'(mif.dout_valid), 32'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (mif.dout_valid) pulses++;
        end
        chk("abort_nopulse", pulses, 0);
        run("post_rst", 8'h02, 4'h5, 4'h1, 12'h00B);

        // random sweep against the q*d+r model
        for (int i = 0; i < 24; i++) begin
            q = int'($urandom_range(0, 255));
            d = int'($urandom_range(0, 15));
            r = int'($urandom_range(0, 15));
            run($sformatf("rnd%0d", i), 8'(q), 4'(d), 4'(r),
                12'(q * d + r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/restore_multiplier.md
RESTORE_MULTIPLIER -- requirements
Module: restore_multiplier

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 4, giving the divisor/remainder width; quotient width is 2*WIDTH and result width is 3*WIDTH.
REQ-002 The block SHALL provide port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL provide port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL provide port quotient, input, 2*WIDTH bits: quotient operand.
REQ-005 The block SHALL provide port divisor, input, WIDTH bits: divisor operand.
REQ-006 The block SHALL provide port remainder, input, WIDTH bits: remainder operand.
REQ-007 The block SHALL provide port din_valid, input, 1 bit: operands valid, a one-cycle capture request.
REQ-008 The block SHALL provide port dout, output, 3*WIDTH bits: reconstructed dividend, registered.
REQ-009 The block SHALL provide port dout_valid, output, 1 bit: one-cycle pulse marking dout as new.
REQ-010 The block SHALL provide port busy, output, 1 bit: high while a computation is in progress.

Function
REQ-011 The block SHALL compute dout = quotient * divisor + remainder, unsigned, exact in 3*WIDTH bits (the maximum value is (2^WIDTH-1)*2^(2*WIDTH), so no overflow or truncation is permitted).
REQ-012 The block SHALL implement a two-state FSM: IDLE (busy=0) and CALC (busy=1).
REQ-013 In IDLE with din_valid=1 at an edge, the block SHALL capture all operands, load accumulator=zero-extended remainder, load shifted addend=zero-extended divisor, clear step counter, and enter CALC.
REQ-014 In IDLE with din_valid=0, the block SHALL hold all registers, with dout keeping its last value.
REQ-015 Each CALC edge SHALL perform one shift-add step, LSB first: if the current quotient LSB=1, add the shifted addend to the accumulator; then shift the addend left 1 and the quotient copy right 1, and increment the counter.
REQ-016 CALC SHALL last exactly 2*WIDTH edges regardless of operand values, with no early termination.
REQ-017 On the 2*WIDTH-th CALC edge, the block SHALL load dout with the final accumulator value including that step, assert dout_valid for exactly the following cycle, and return to IDLE.
REQ-018 Latency from the capture edge to the cycle in which dout_valid is high SHALL be 2*WIDTH cycles; throughput SHALL be one operation per 2*WIDTH+1 cycles.
REQ-019 din_valid asserted while busy=1 SHALL be ignored, with the operands not captured and the computation unaffected.
REQ-020 din_valid asserted in the cycle dout_valid=1 (state IDLE) SHALL be accepted as a new capture, giving back-to-back operation.
REQ-021 Operand changes after the capture edge SHALL NOT affect the result.
REQ-022 divisor=0 SHALL yield dout=remainder, and quotient=0 SHALL yield dout=remainder, both after full latency.
REQ-023 The remainder input SHALL NOT be range-checked against divisor; the formula applies as given.

Reset
REQ-024 With rst=1 at an edge, the block SHALL clear dout, dout_valid, busy, the accumulator, counter and operand copies, and enter IDLE.
REQ-025 Reset SHALL take priority over din_valid and over any CALC step.
REQ-026 Reset asserted mid-CALC SHALL abort the operation, with no dout_valid pulse produced for it.

Verification (WIDTH=4)
REQ-027 The bench SHALL check quotient=0x0D, divisor=0x3, remainder=0x2, pulse din_valid -> busy high for 8 cycles, then dout=0x029 with dout_valid high for 1 cycle, 8 cycles after capture.
REQ-028 The bench SHALL check quotient=0xFF, divisor=0xF, remainder=0xE -> dout=0xEFF (max case, no overflow).
REQ-029 The bench SHALL check divisor=0x0, quotient=0xA5, remainder=0x7 -> dout=0x007 after 8 cycles; separately, quotient=0x00, divisor=0x9, remainder=0x5 -> dout=0x005.
REQ-030 The bench SHALL check capture (0x0D,0x3,0x2), then din_valid with (0xFF,0xF,0xE) on cycle 3 of CALC -> ignored, dout=0x029; a new din_valid in the dout_valid cycle -> accepted, next dout=0xEFF 8 cycles later.
REQ-031 The bench SHALL check rst=1 on CALC cycle 4 -> next cycle busy=0, dout=0, dout_valid=0, and no pulse follows; a subsequent capture of (0x02,0x5,0x1) -> dout=0x00B.
REQ-032 The bench SHALL run a randomized sweep of all operands, with dout compared against the q*d+r reference model on every dout_valid pulse.
